me_unit: RTL and testbench

Memory-access pipeline stage between the execute stage and write-back. Latches the EX-to-ME bus and waits for the data-SRAM response on loads. Aligns and sign/zero-extends load data, then forwards the result to WB. Also provides the stage's register-forwarding, CSR-bypass and exception-kill signals to the upstream stages.

---
 rtl/me_unit_pkg.sv | 54 +++++
 rtl/me_unit_load_align.sv | 23 ++
 rtl/me_unit.sv | 158 +++++++++++++++
 tb/tb_me_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_unit_pkg.sv
// Shared stage-bus sizes and payload layouts for the memory-access stage.
package me_unit_pkg;

  localparam int unsigned EX_to_ME_Bus_Size = 131;
  localparam int unsigned ME_to_WB_Bus_Size = 124;
  localparam int unsigned ME_to_EX_Bus_Size = 47;
  localparam int unsigned DataW             = 32;
  localparam int unsigned RegW              = 5;
  localparam int unsigned CsrNumW           = 14;
  localparam int unsigned ExcpNumW          = 6;

  // Load access descriptor: {signed, byte, half, offset[1:0]}
  typedef struct packed {
    logic       sgn;
    logic       is_byte;
    logic       is_half;
    logic [1:0] offset;
  } dest_flag_t;

  typedef struct packed {
    logic                excp_en;
    logic [ExcpNumW-1:0] excp_num;
    logic [CsrNumW-1:0]  csr_num;
    logic                csr_we;
    logic [DataW-1:0]    csr_wvalue;
    logic                ertn;
    dest_flag_t          dest_flag;
    logic [DataW-1:0]    pc;
    logic [DataW-1:0]    result;
    logic                res_from_mem;
    logic                gr_we;
    logic [RegW-1:0]     dest;
  } ex_to_me_t;

  // Write enable is folded into wb_dest: a zero destination means no write.
  typedef struct packed {
    logic                excp_en;
    logic [ExcpNumW-1:0] excp_num;
    logic [CsrNumW-1:0]  csr_num;
    logic                csr_we;
    logic [DataW-1:0]    csr_wvalue;
    logic                ertn;
    logic [DataW-1:0]    pc;
    logic [DataW-1:0]    final_result;
    logic [RegW-1:0]     wb_dest;
  } me_to_wb_t;

  typedef struct packed {
    logic [CsrNumW-1:0] csr_num;
    logic               csr_we;
    logic [DataW-1:0]   csr_wvalue;
  } me_to_ex_t;

endpackage

// File: rtl/me_unit_load_align.sv
// Load data alignment: selects byte/half lane by offset and extends it.
module me_unit_load_align
  import me_unit_pkg::*;
(
  input  logic [DataW-1:0] rdata,
  input  dest_flag_t       dest_flag,
  output logic [DataW-1:0] aligned_c
);

  logic [DataW-1:0] shifted;

  // Shift the addressed lane down, then sign- or zero-extend it.
  always_comb begin
    shifted   = rdata >> {dest_flag.offset, 3'b000};
    aligned_c = rdata;
    if (dest_flag.is_byte) begin
      aligned_c = {{24{dest_flag.sgn & shifted[7]}}, shifted[7:0]};
    end else if (dest_flag.is_half) begin
      aligned_c = {{16{dest_flag.sgn & shifted[15]}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/me_unit.sv
// Memory-access pipeline stage: holds the EX bus, waits for load data,
// aligns it and forwards the result plus hazard/bypass signals.
module me_unit
  import me_unit_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         EX_to_ME_Valid,
  input  logic [EX_to_ME_Bus_Size-1:0] EX_to_ME_Bus,
  output logic                         ME_Allow_in,
  input  logic                         WB_Allow_in,
  output logic                         ME_to_WB_Valid,
  output logic [ME_to_WB_Bus_Size-1:0] ME_to_WB_Bus,
  input  logic                         data_sram_data_ok,
  input  logic [DataW-1:0]             data_sram_rdata,
  input  logic                         excp_flush,
  input  logic                         ertn_flush,
  output logic [RegW-1:0]              ME_dest,
  output logic [DataW-1:0]             ME_Forward_Res,
  output logic                         ME_Ld_wait,
  output logic [ME_to_EX_Bus_Size-1:0] ME_to_EX_Bus,
  output logic                         ME_excp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HAVE = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             me_valid_q;
  ex_to_me_t        bus_q;
  ex_to_me_t        ex_bus;
  logic [DataW-1:0] data_buf_q;
  logic [DataW-1:0] load_data;
  logic [DataW-1:0] final_result;
  logic             flush, is_load, ready_go, load_accept, handover;
  logic             data_have, in_drop, buf_load;
  me_to_wb_t        wb_bus;
  me_to_ex_t        ex_byp;

  assign ex_bus      = EX_to_ME_Bus;
  assign flush       = excp_flush | ertn_flush;
  assign is_load     = bus_q.res_from_mem & ~bus_q.excp_en;
  assign ready_go    = ~(is_load & ~data_have);
  assign ME_Allow_in = ~in_drop & (~me_valid_q | (ready_go & WB_Allow_in));
  assign ME_to_WB_Valid = me_valid_q & ready_go;
  assign handover    = ME_to_WB_Valid & WB_Allow_in;
  assign load_accept = ME_Allow_in & EX_to_ME_Valid & ex_bus.res_from_mem & ~ex_bus.excp_en;

  // Stage valid bit: flush wins, otherwise refill whenever the stage accepts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      me_valid_q <= 1'b0;
    end else if (flush) begin
      me_valid_q <= 1'b0;
    end else if (ME_Allow_in) begin
      me_valid_q <= EX_to_ME_Valid;
    end
  end

  // Payload register captures the EX bus on every accepted hand-over.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q <= '0;
    end else if (ME_Allow_in && EX_to_ME_Valid) begin
      bus_q <= ex_bus;
    end
  end

  // Response FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM next state; DROP swallows the response of a flushed load.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!flush && load_accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)                  state_d = data_sram_data_ok ? S_IDLE : S_DROP;
        else if (data_sram_data_ok) state_d = S_HAVE;
      end
      S_HAVE: begin
        if (flush)            state_d = S_IDLE;
        else if (load_accept) state_d = S_WAIT;
        else if (handover)    state_d = S_IDLE;
      end
      S_DROP: begin
        if (data_sram_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response FSM decoded outputs.
  always_comb begin
    data_have = 1'b0;
    in_drop   = 1'b0;
    buf_load  = 1'b0;
    unique case (state_q)
      S_WAIT:  buf_load  = data_sram_data_ok & ~flush;
      S_HAVE:  data_have = 1'b1;
      S_DROP:  in_drop   = 1'b1;
      default: ;
    endcase
  end

  // Load data buffer, filled only by a response that will be consumed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_buf_q <= '0;
    end else if (buf_load) begin
      data_buf_q <= data_sram_rdata;
    end
  end

  me_unit_load_align u_load_align (
    .rdata     (data_buf_q),
    .dest_flag (bus_q.dest_flag),
    .aligned_c (load_data)
  );

  assign final_result = bus_q.res_from_mem ? load_data : bus_q.result;

  // Assemble outgoing WB and CSR-bypass payloads.
  always_comb begin
    wb_bus              = '0;
    wb_bus.excp_en      = bus_q.excp_en;
    wb_bus.excp_num     = bus_q.excp_num;
    wb_bus.csr_num      = bus_q.csr_num;
    wb_bus.csr_we       = bus_q.csr_we;
    wb_bus.csr_wvalue   = bus_q.csr_wvalue;
    wb_bus.ertn         = bus_q.ertn;
    wb_bus.pc           = bus_q.pc;
    wb_bus.final_result = final_result;
    wb_bus.wb_dest      = (bus_q.gr_we && !bus_q.excp_en) ? bus_q.dest : 5'd0;
    ex_byp              = '0;
    ex_byp.csr_num      = bus_q.csr_num;
    ex_byp.csr_we       = bus_q.csr_we & me_valid_q;
    ex_byp.csr_wvalue   = bus_q.csr_wvalue;
  end

  assign ME_to_WB_Bus   = wb_bus;
  assign ME_to_EX_Bus   = ex_byp;
  assign ME_Forward_Res = final_result;
  assign ME_dest        = (me_valid_q && bus_q.gr_we) ? bus_q.dest : 5'd0;
  assign ME_Ld_wait     = me_valid_q & is_load & ~data_have;
  assign ME_excp        = me_valid_q & (bus_q.excp_en | bus_q.ertn);

endmodule

// File: tb/tb_me_unit.sv
// Directed bench for me_unit: vector table plus multi-cycle corner sequences.
module tb_me_unit;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_valid;
  logic [130:0] ex_bus;
  logic         me_allow_in;
  logic         wb_allow_in;
  logic         wb_valid;
  logic [123:0] wb_bus;
  logic         data_ok;
  logic [31:0]  rdata;
  logic         excp_flush, ertn_flush;
  logic [4:0]   me_dest;
  logic [31:0]  fwd_res;
  logic         ld_wait;
  logic [46:0]  me_to_ex;
  logic         me_excp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  me_unit dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_to_ME_Valid    (ex_valid),
    .EX_to_ME_Bus      (ex_bus),
    .ME_Allow_in       (me_allow_in),
    .WB_Allow_in       (wb_allow_in),
    .ME_to_WB_Valid    (wb_valid),
    .ME_to_WB_Bus      (wb_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush),
    .ME_dest           (me_dest),
    .ME_Forward_Res    (fwd_res),
    .ME_Ld_wait        (ld_wait),
    .ME_to_EX_Bus      (me_to_ex),
    .ME_excp           (me_excp)
  );

  typedef struct {
    logic        rfm;
    logic        sgn;
    logic        is_b;
    logic        is_h;
    logic [1:0]  off;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] rdata;
    logic [31:0] exp_res;
    logic [4:0]  exp_dest;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [130:0] mk_bus(
    input logic excp_en, input logic [5:0] excp_num, input logic [13:0] csr_num,
    input logic csr_we, input logic [31:0] csr_wvalue, input logic ertn,
    input logic [4:0] flag, input logic [31:0] pc, input logic [31:0] result,
    input logic rfm, input logic gr_we, input logic [4:0] dest);
    return {excp_en, excp_num, csr_num, csr_we, csr_wvalue, ertn, flag, pc, result, rfm, gr_we, dest};
  endfunction

  function automatic logic [130:0] ldw_bus(input logic [4:0] dest);
    return mk_bus(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 5'b00000, 32'h1c001000, 32'd0, 1'b1, 1'b1, dest);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full ld.w transaction with data_ok one cycle after acceptance.
  task automatic do_load(input string tag, input logic [31:0] rd);
    tick(); ex_valid = 1'b1; ex_bus = ldw_bus(5'd1);
    tick(); ex_valid = 1'b0; data_ok = 1'b1; rdata = rd;
    tick(); data_ok = 1'b0; rdata = 32'hA5A5A5A5;
    #1;
    chk({tag, "_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_result"}, 64'(wb_bus[36:5]), 64'(rd));
    tick();
    chk({tag, "_done"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    vec_t v;
    //            rfm  sgn  b    h    off    gw   dest   result        rdata         exp_res       exp_dest
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,2'd0,1'b1,5'd5, 32'h0,        32'h89ABCDEF,32'h89ABCDEF,5'd5};
    vecs[1] = '{1'b1,1'b1,1'b1,1'b0,2'd3,1'b1,5'd6, 32'h0,        32'h80FF0000,32'hFFFFFF80,5'd6};
    vecs[2] = '{1'b1,1'b0,1'b1,1'b0,2'd3,1'b1,5'd6, 32'h0,        32'h80FF0000,32'h00000080,5'd6};
    vecs[3] = '{1'b1,1'b1,1'b0,1'b1,2'd2,1'b1,5'd10,32'h0,        32'h80011234,32'hFFFF8001,5'd10};
    vecs[4] = '{1'b1,1'b0,1'b0,1'b1,2'd0,1'b1,5'd11,32'h0,        32'h1234F00D,32'h0000F00D,5'd11};
    vecs[5] = '{1'b1,1'b1,1'b1,1'b0,2'd1,1'b1,5'd12,32'h0,        32'h00007F00,32'h0000007F,5'd12};
    vecs[6] = '{1'b1,1'b0,1'b1,1'b0,2'd0,1'b1,5'd13,32'h0,        32'h123456AB,32'h000000AB,5'd13};
    vecs[7] = '{1'b1,1'b1,1'b0,1'b1,2'd2,1'b1,5'd14,32'h0,        32'h7FFF0000,32'h00007FFF,5'd14};
    vecs[8] = '{1'b0,1'b0,1'b0,1'b0,2'd0,1'b1,5'd7, 32'hDEADBEEF, 32'h0,       32'hDEADBEEF,5'd7};
    vecs[9] = '{1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,5'd9, 32'h00000042, 32'h0,       32'h00000042,5'd0};

    resetn = 1'b0; ex_valid = 1'b0; ex_bus = '0; wb_allow_in = 1'b1;
    data_ok = 1'b0; rdata = '0; excp_flush = 1'b0; ertn_flush = 1'b0;
    #12;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_allow_in", 64'(me_allow_in), 64'd1);
    chk("rst_me_dest", 64'(me_dest), 64'd0);
    chk("rst_ld_wait", 64'(ld_wait), 64'd0);
    chk("rst_excp", 64'(me_excp), 64'd0);
    chk("rst_csr_we", 64'(me_to_ex[32]), 64'd0);
    @(negedge clk); resetn = 1'b1;

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      tick(); ex_valid = 1'b1;
      ex_bus = mk_bus(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, {v.sgn, v.is_b, v.is_h, v.off},
                      32'(32'h1c000000 + i * 4), v.result, v.rfm, v.gr_we, v.dest);
      #1 chk("vec_allow_in", 64'(me_allow_in), 64'd1);
      tick(); ex_valid = 1'b0;
      if (v.rfm) begin data_ok = 1'b1; rdata = v.rdata; end
      #1;
      chk("vec_ld_wait", 64'(ld_wait), 64'(v.rfm));
      chk("vec_me_dest", 64'(me_dest), 64'(v.exp_dest));
      chk("vec_wb_valid_first", 64'(wb_valid), 64'(!v.rfm));
      if (v.rfm) begin
        tick(); data_ok = 1'b0; rdata = 32'h5A5A5A5A;
        #1 chk("vec_wb_valid_load", 64'(wb_valid), 64'd1);
      end
      chk("vec_final_result", 64'(wb_bus[36:5]), 64'(v.exp_res));
      chk("vec_forward", 64'(fwd_res), 64'(v.exp_res));
      chk("vec_wb_dest", 64'(wb_bus[4:0]), 64'(v.exp_dest));
      chk("vec_wb_pc", 64'(wb_bus[68:37]), 64'(32'h1c000000 + i * 4));
      tick();
      chk("vec_wb_valid_after", 64'(wb_valid), 64'd0);
    end

    // ld.hu with late data and WB back-pressure; an ALU op waits behind it.
    tick(); ex_valid = 1'b1;
    ex_bus = mk_bus(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 5'b00110, 32'h1c002000, 32'd0, 1'b1, 1'b1, 5'd8);
    tick();
    ex_bus = mk_bus(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b0, 5'b00000, 32'h1c002004, 32'h00007777, 1'b0, 1'b1, 5'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ld_wait", 64'(ld_wait), 64'd1);
      chk("stall_allow_in", 64'(me_allow_in), 64'd0);
      tick();
    end
    data_ok = 1'b1; rdata = 32'hBEEF0000; wb_allow_in = 1'b0;
    #1 chk("stall_ld_wait_dok", 64'(ld_wait), 64'd1);
    chk("stall_allow_in_dok", 64'(me_allow_in), 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick(); data_ok = 1'b0; rdata = 32'h0;
      #1;
      chk("hold_ld_wait", 64'(ld_wait), 64'd0);
      chk("hold_wb_valid", 64'(wb_valid), 64'd1);
      chk("hold_allow_in", 64'(me_allow_in), 64'd0);
      chk("hold_result", 64'(wb_bus[36:5]), 64'h0000BEEF);
    end
    tick(); wb_allow_in = 1'b1;
    #1 chk("release_allow_in", 64'(me_allow_in), 64'd1);
    tick(); ex_valid = 1'b0;
    #1 chk("next_wb_valid", 64'(wb_valid), 64'd1);
    chk("next_result", 64'(wb_bus[36:5]), 64'h00007777);
    tick();
    chk("next_done", 64'(wb_valid), 64'd0);

    // Flush while waiting: the stale response is dropped, new load blocked.
    tick(); ex_valid = 1'b1; ex_bus = ldw_bus(5'd3);
    tick(); ex_valid = 1'b0; excp_flush = 1'b1;
    tick(); excp_flush = 1'b0; ex_valid = 1'b1; ex_bus = ldw_bus(5'd4);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin data_ok = 1'b1; rdata = 32'h22222222; end
      #1;
      chk("drop_allow_in", 64'(me_allow_in), 64'd0);
      chk("drop_wb_valid", 64'(wb_valid), 64'd0);
      tick();
    end
    data_ok = 1'b0;
    #1 chk("drop_exit_allow_in", 64'(me_allow_in), 64'd1);
    chk("drop_exit_wb_valid", 64'(wb_valid), 64'd0);
    tick(); ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h11111111;
    #1 chk("after_drop_ld_wait", 64'(ld_wait), 64'd1);
    tick(); data_ok = 1'b0; rdata = 32'h22222222;
    #1 chk("after_drop_valid", 64'(wb_valid), 64'd1);
    chk("after_drop_result", 64'(wb_bus[36:5]), 64'h11111111);
    tick();
    chk("after_drop_done", 64'(wb_valid), 64'd0);

    // CSR bypass, valid gating, exception and ertn signalling.
    tick(); ex_valid = 1'b1; wb_allow_in = 1'b0;
    ex_bus = mk_bus(1'b0, 6'd0, 14'h5, 1'b1, 32'hCAFEF00D, 1'b0, 5'b00000, 32'h1c003000, 32'h10, 1'b0, 1'b1, 5'd3);
    tick(); ex_valid = 1'b0;
    #1 chk("csr_bypass", 64'(me_to_ex), 64'({14'h5, 1'b1, 32'hCAFEF00D}));
    chk("csr_excp", 64'(me_excp), 64'd0);
    wb_allow_in = 1'b1;
    tick();
    chk("csr_we_gated", 64'(me_to_ex[32]), 64'd0);
    ex_valid = 1'b1;
    ex_bus = mk_bus(1'b1, 6'h0C, 14'd0, 1'b0, 32'd0, 1'b0, 5'b00000, 32'h1c003004, 32'h99, 1'b0, 1'b1, 5'd4);
    tick();
    ex_bus = mk_bus(1'b0, 6'd0, 14'd0, 1'b0, 32'd0, 1'b1, 5'b00000, 32'h1c003008, 32'h0, 1'b0, 1'b0, 5'd0);
    #1 chk("excp_me_excp", 64'(me_excp), 64'd1);
    chk("excp_wb_valid", 64'(wb_valid), 64'd1);
    chk("excp_wb_en", 64'(wb_bus[123]), 64'd1);
    chk("excp_wb_num", 64'(wb_bus[122:117]), 64'h0C);
    chk("excp_wb_dest", 64'(wb_bus[4:0]), 64'd0);
    tick(); ex_valid = 1'b0;
    #1 chk("ertn_me_excp", 64'(me_excp), 64'd1);
    chk("ertn_wb_bit", 64'(wb_bus[69]), 64'd1);
    tick();
    chk("ertn_gone", 64'(me_excp), 64'd0);

    // Flush coinciding with data_ok in WAIT goes straight back to IDLE.
    tick(); ex_valid = 1'b1; ex_bus = ldw_bus(5'd5);
    tick(); ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h33333333; excp_flush = 1'b1;
    tick(); data_ok = 1'b0; excp_flush = 1'b0;
    #1 chk("flush_dok_allow_in", 64'(me_allow_in), 64'd1);
    chk("flush_dok_wb_valid", 64'(wb_valid), 64'd0);
    do_load("flush_dok_next", 32'h44444444);

    // Flush while holding data under back-pressure.
    tick(); ex_valid = 1'b1; ex_bus = ldw_bus(5'd6);
    tick(); ex_valid = 1'b0; data_ok = 1'b1; rdata = 32'h55555555; wb_allow_in = 1'b0;
    tick(); data_ok = 1'b0;
    #1 chk("have_wb_valid", 64'(wb_valid), 64'd1);
    ertn_flush = 1'b1;
    tick(); ertn_flush = 1'b0; wb_allow_in = 1'b1;
    #1 chk("have_flush_valid", 64'(wb_valid), 64'd0);
    chk("have_flush_allow_in", 64'(me_allow_in), 64'd1);
    do_load("have_flush_next", 32'h66666666);

    // Asynchronous reset in the middle of a wait.
    tick(); ex_valid = 1'b1; ex_bus = ldw_bus(5'd7);
    tick(); ex_valid = 1'b0;
    #1 chk("pre_rst_ld_wait", 64'(ld_wait), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("mid_rst_ld_wait", 64'(ld_wait), 64'd0);
    chk("mid_rst_allow_in", 64'(me_allow_in), 64'd1);
    chk("mid_rst_me_dest", 64'(me_dest), 64'd0);
    chk("mid_rst_excp", 64'(me_excp), 64'd0);
    chk("mid_rst_csr_we", 64'(me_to_ex[32]), 64'd0);
    #2 resetn = 1'b1;
    do_load("post_rst", 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
